rs_kes_bm: RTL and testbench

- Key-equation solver for the RS(255,247) decoder, t=4, GF(2^8) with primitive polynomial 0x11d.
- Sits directly downstream of the syndrome stage and consumes its syndrome_val pulse and syndrome1..syndrome8.
- Runs the inversionless Berlekamp–Massey algorithm (iBM), producing error-locator Λ(x) (degree ≤4), its degree L, and a fail flag for the Chien/Forney stage.
- Iterative, time-shared datapath: 5 GF multipliers for discrepancy, 10 for the polynomial update.

---
 rtl/rs_pkg.sv | 20 ++
 rtl/gf256mul.sv | 25 ++
 rtl/rs_kes_disc.sv | 28 ++
 rtl/rs_kes_bm.sv | 238 +++++++++++++++++++++++
 tb/tb_rs_kes_bm.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared types and constants for the RS(255,247) t=4 key-equation solver.
// GF(2^8) uses primitive polynomial 0x11d; only its low byte is kept here.
package rs_pkg;

    localparam int unsigned GF_W  = 8;
    localparam int unsigned RS_T  = 4;
    localparam int unsigned RS_2T = 8;
    localparam logic [7:0]  GF_POLY = 8'h1d;

    typedef logic [GF_W-1:0] gf_t;
    typedef gf_t [RS_T:0]    gf_poly_t;

    typedef enum logic [1:0] {
        StIdle,
        StDisc,
        StUpdt,
        StOmega
    } kes_state_e;

endpackage

// File: rtl/gf256mul.sv
// Combinational GF(2^8) multiplier, shift-and-add with reduction by 0x11d.
module gf256mul
    import rs_pkg::*;
(
    input  logic [GF_W-1:0] a,
    input  logic [GF_W-1:0] b,
    output logic [GF_W-1:0] z
);

    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;

    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[GF_W-2:0], 1'b0} ^ (sh[GF_W-1] ? GF_POLY : '0);
        end
        z = acc;
    end

endmodule

// File: rtl/rs_kes_disc.sv
// Five-term GF(2^8) inner product; computes the BM discrepancy and, when enabled,
// the error-evaluator coefficients.
module rs_kes_disc
    import rs_pkg::*;
(
    input  gf_poly_t coef_i,
    input  gf_poly_t syn_i,
    output gf_t      sum_o
);

    gf_poly_t prod;

    for (genvar i = 0; i <= RS_T; i++) begin : g_mul
        gf256mul u_mul (
            .a(coef_i[i]),
            .b(syn_i[i]),
            .z(prod[i])
        );
    end

    always_comb begin
        sum_o = '0;
        for (int i = 0; i <= RS_T; i++) begin
            sum_o = sum_o ^ prod[i];
        end
    end

endmodule

// File: rtl/rs_kes_bm.sv
// Inversionless Berlekamp-Massey key-equation solver for RS(255,247), t=4.
// Define RS_KES_OMEGA_EN to also compute omega0..3 in a 4-cycle OMEGA phase.
module rs_kes_bm
    import rs_pkg::*;
#(
    parameter int unsigned T = RS_T
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       syndrome_val,
    input  logic [7:0] syndrome1,
    input  logic [7:0] syndrome2,
    input  logic [7:0] syndrome3,
    input  logic [7:0] syndrome4,
    input  logic [7:0] syndrome5,
    input  logic [7:0] syndrome6,
    input  logic [7:0] syndrome7,
    input  logic [7:0] syndrome8,
    output logic       busy,
    output logic       lambda_val,
    output logic [7:0] lambda0,
    output logic [7:0] lambda1,
    output logic [7:0] lambda2,
    output logic [7:0] lambda3,
    output logic [7:0] lambda4,
    output logic [3:0] lambda_deg,
    output logic       fail,
    output logic       zero_syn,
    output logic [7:0] omega0,
    output logic [7:0] omega1,
    output logic [7:0] omega2,
    output logic [7:0] omega3
);

    localparam logic [3:0] LastR = 4'(2 * T - 1);

    kes_state_e                  state_q, state_d;
    logic [RS_2T-1:0][GF_W-1:0]  syn_q, syn_d;
    gf_poly_t                    lam_q, lam_d, b_q, b_d, out_lam_q, out_lam_d;
    gf_poly_t                    b_sh, gam_lam, dlt_b, lam_new, syn_sel;
    gf_t                         gamma_q, gamma_d, delta_q, delta_d, disc;
    logic [3:0]                  r_q, r_d, l_q, l_d, deg_q, deg_d, l_upd, syn_idx;
    logic                        zero_q, zero_d, busy_q, busy_d, val_q, val_d;
    logic                        fail_q, fail_d, zs_q, zs_d, do_swap;
`ifdef RS_KES_OMEGA_EN
    gf_t [RS_T-1:0]              om_q, om_d, om_out_q, om_out_d;
`endif

    // Syndrome S_(r+1-i) feeds tap i; indices below S1 read as zero.
    always_comb begin
        syn_idx = '0;
        for (int i = 0; i <= RS_T; i++) begin
            syn_idx    = r_q - 4'(i);
            syn_sel[i] = (r_q >= 4'(i) && syn_idx < 4'(RS_2T)) ? syn_q[syn_idx[2:0]] : '0;
        end
    end

    rs_kes_disc u_disc (
        .coef_i(lam_q),
        .syn_i (syn_sel),
        .sum_o (disc)
    );

    assign b_sh = {b_q[RS_T-1:0], 8'h00};

    for (genvar i = 0; i <= RS_T; i++) begin : g_upd
        gf256mul u_gl (
            .a(gamma_q),
            .b(lam_q[i]),
            .z(gam_lam[i])
        );
        gf256mul u_db (
            .a(delta_q),
            .b(b_sh[i]),
            .z(dlt_b[i])
        );
    end

    assign lam_new = gam_lam ^ dlt_b;
    assign do_swap = (delta_q != '0) && ({l_q, 1'b0} <= {1'b0, r_q});
    assign l_upd   = do_swap ? (r_q + 4'd1 - l_q) : l_q;

    always_comb begin
        state_d   = state_q;
        syn_d     = syn_q;
        lam_d     = lam_q;
        b_d       = b_q;
        gamma_d   = gamma_q;
        delta_d   = delta_q;
        r_d       = r_q;
        l_d       = l_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        val_d     = 1'b0;
        out_lam_d = out_lam_q;
        deg_d     = deg_q;
        fail_d    = fail_q;
        zs_d      = zs_q;
`ifdef RS_KES_OMEGA_EN
        om_d      = om_q;
        om_out_d  = om_out_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (syndrome_val) begin
                    syn_d   = {syndrome8, syndrome7, syndrome6, syndrome5,
                               syndrome4, syndrome3, syndrome2, syndrome1};
                    zero_d  = (syn_d == '0);
                    lam_d   = gf_poly_t'(1);
                    b_d     = gf_poly_t'(1);
                    l_d     = '0;
                    gamma_d = 8'h01;
                    r_d     = '0;
                    busy_d  = 1'b1;
                    state_d = StDisc;
                end
            end
            StDisc: begin
                delta_d = disc;
                state_d = StUpdt;
            end
            StUpdt: begin
                lam_d = lam_new;
                l_d   = l_upd;
                r_d   = r_q + 4'd1;
                if (do_swap) begin
                    b_d     = lam_q;
                    gamma_d = delta_q;
                end else begin
                    b_d = b_sh;
                end
                if (r_q == LastR) begin
`ifdef RS_KES_OMEGA_EN
                    state_d = StOmega;
                    r_d     = '0;
`else
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    val_d     = 1'b1;
                    out_lam_d = lam_new;
                    deg_d     = l_upd;
                    fail_d    = l_upd > 4'(RS_T);
                    zs_d      = zero_q;
`endif
                end else begin
                    state_d = StDisc;
                end
            end
            StOmega: begin
`ifdef RS_KES_OMEGA_EN
                // r doubles as k; the shared datapath gives omega_k directly.
                om_d[r_q[1:0]] = disc;
                r_d            = r_q + 4'd1;
                if (r_q == 4'(RS_T - 1)) begin
                    state_d   = StIdle;
                    busy_d    = 1'b0;
                    val_d     = 1'b1;
                    out_lam_d = lam_q;
                    deg_d     = l_q;
                    fail_d    = l_q > 4'(RS_T);
                    zs_d      = zero_q;
                    om_out_d  = om_d;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            syn_q     <= '0;
            lam_q     <= '0;
            b_q       <= '0;
            gamma_q   <= '0;
            delta_q   <= '0;
            r_q       <= '0;
            l_q       <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            val_q     <= 1'b0;
            out_lam_q <= '0;
            deg_q     <= '0;
            fail_q    <= 1'b0;
            zs_q      <= 1'b0;
`ifdef RS_KES_OMEGA_EN
            om_q      <= '0;
            om_out_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            syn_q     <= syn_d;
            lam_q     <= lam_d;
            b_q       <= b_d;
            gamma_q   <= gamma_d;
            delta_q   <= delta_d;
            r_q       <= r_d;
            l_q       <= l_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            val_q     <= val_d;
            out_lam_q <= out_lam_d;
            deg_q     <= deg_d;
            fail_q    <= fail_d;
            zs_q      <= zs_d;
`ifdef RS_KES_OMEGA_EN
            om_q      <= om_d;
            om_out_q  <= om_out_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign lambda_val = val_q;
    assign lambda0    = out_lam_q[0];
    assign lambda1    = out_lam_q[1];
    assign lambda2    = out_lam_q[2];
    assign lambda3    = out_lam_q[3];
    assign lambda4    = out_lam_q[4];
    assign lambda_deg = deg_q;
    assign fail       = fail_q;
    assign zero_syn   = zs_q;
`ifdef RS_KES_OMEGA_EN
    assign omega0     = om_out_q[0];
    assign omega1     = om_out_q[1];
    assign omega2     = om_out_q[2];
    assign omega3     = om_out_q[3];
`else
    assign omega0     = '0;
    assign omega1     = '0;
    assign omega2     = '0;
    assign omega3     = '0;
`endif

endmodule

// File: tb/tb_rs_kes_bm.sv
// Bench for rs_kes_bm: fixed vectors, random error patterns against a locator-product
// model (Lambda compared up to scale), and busy/back-to-back/reset sequences.
module tb_rs_kes_bm;

`ifdef RS_KES_OMEGA_EN
    localparam int Lat = 20;
`else
    localparam int Lat = 16;
`endif

    typedef struct {
        logic [7:0][7:0] s;
        logic [4:0][7:0] lam;
        logic [3:0][7:0] omg;
        int              deg;
        bit              fl;
        bit              zero;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            syndrome_val = 1'b0;
    logic [7:0][7:0] syn_in = '0;
    logic            busy, lambda_val, fail, zero_syn;
    logic [4:0][7:0] lam_o;
    logic [3:0][7:0] om_o;
    logic [3:0]      lambda_deg;

    int        checks = 0;
    int        errors = 0;
    logic [7:0] gexp [512];
    int         glog [256];
    int         err_pos [4];
    logic [7:0] err_val [4];

    always #5 clk = ~clk;

    rs_kes_bm dut (
        .clk(clk), .rst_n(rst_n), .syndrome_val(syndrome_val),
        .syndrome1(syn_in[0]), .syndrome2(syn_in[1]), .syndrome3(syn_in[2]),
        .syndrome4(syn_in[3]), .syndrome5(syn_in[4]), .syndrome6(syn_in[5]),
        .syndrome7(syn_in[6]), .syndrome8(syn_in[7]),
        .busy(busy), .lambda_val(lambda_val),
        .lambda0(lam_o[0]), .lambda1(lam_o[1]), .lambda2(lam_o[2]),
        .lambda3(lam_o[3]), .lambda4(lam_o[4]),
        .lambda_deg(lambda_deg), .fail(fail), .zero_syn(zero_syn),
        .omega0(om_o[0]), .omega1(om_o[1]), .omega2(om_o[2]), .omega3(om_o[3])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return gexp[glog[a] + glog[b]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Syndromes from an error pattern, locator as prod(1 + X_k x), omega = Lambda*S mod x^4.
    function automatic vec_t make_vec(input int n);
        vec_t v;
        v.s = '0;
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < n; k++)
                v.s[j] ^= gmul(err_val[k], gexp[((j + 1) * err_pos[k]) % 255]);
        v.lam = 40'h01;
        for (int k = 0; k < n; k++)
            for (int i = 4; i >= 1; i--)
                v.lam[i] ^= gmul(gexp[err_pos[k]], v.lam[i-1]);
        v.omg = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j <= k; j++)
                v.omg[k] ^= gmul(v.lam[j], v.s[k-j]);
        v.deg  = n;
        v.fl   = 1'b0;
        v.zero = (n == 0);
        return v;
    endfunction

    task automatic wait_val(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) check("busy_rise", {31'd0, busy}, 1);
            if (lambda_val) begin
                lat = c;
                check("busy_fall", {31'd0, busy}, 0);
                break;
            end
        end
    endtask

    task automatic check_out(input vec_t v, input string tag);
        check({tag, "_lam0_nonzero"}, {31'd0, lam_o[0] != 0}, 1);
        for (int i = 1; i < 5; i++)
            check($sformatf("%s_lam%0d", tag, i), {24'd0, lam_o[i]},
                  {24'd0, gmul(v.lam[i], lam_o[0])});
        check({tag, "_deg"}, {28'd0, lambda_deg}, v.deg);
        check({tag, "_fail"}, {31'd0, fail}, {31'd0, v.fl});
        check({tag, "_zero"}, {31'd0, zero_syn}, {31'd0, v.zero});
`ifdef RS_KES_OMEGA_EN
        for (int k = 0; k < 4; k++)
            check($sformatf("%s_om%0d", tag, k), {24'd0, om_o[k]},
                  {24'd0, gmul(v.omg[k], lam_o[0])});
`else
        check({tag, "_om"}, om_o, 0);
`endif
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        syn_in = v.s;
        syndrome_val = 1'b1;
        @(posedge clk); #1;
        syndrome_val = 1'b0;
        wait_val(lat);
        check({tag, "_lat"}, lat, Lat);
        check_out(v, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_val"}, {31'd0, lambda_val}, 0);
        check({tag, "_lam"}, lam_o[3:0], 0);
        check({tag, "_lam4"}, {24'd0, lam_o[4]}, 0);
        check({tag, "_deg_fail_zero"}, {26'd0, lambda_deg, fail, zero_syn}, 0);
        check({tag, "_om"}, om_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [5];
        vec_t v, v2;
        int   lat, pulses, first;
        logic [8:0] x;

        x = 9'h001;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x[7:0];
            glog[x[7:0]] = i;
            x = {x[7:0], 1'b0};
            if (x[8]) x = x ^ 9'h11d;
        end
        for (int i = 255; i < 512; i++) gexp[i] = gexp[i-255];
        glog[0] = 0;

        tbl[0] = '{s: 64'h0, lam: 40'h01, omg: 32'h0, deg: 0, fl: 1'b0, zero: 1'b1};
        tbl[1] = '{s: 64'h0101010101010101, lam: 40'h0101, omg: 32'h01,
                   deg: 1, fl: 1'b0, zero: 1'b0};
        tbl[2] = '{s: 64'h1d80402010080402, lam: 40'h0201, omg: 32'h02,
                   deg: 1, fl: 1'b0, zero: 1'b0};
        // Complexity jumps to 8 on the last syndrome: uncorrectable.
        tbl[3] = '{s: 64'h0100000000000000, lam: 40'h01, omg: 32'h0,
                   deg: 8, fl: 1'b1, zero: 1'b0};
        err_pos = '{3, 50, 100, 200};
        err_val = '{8'h05, 8'h80, 8'h33, 8'h01};
        tbl[4] = make_vec(4);

        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) run_vec(tbl[t], $sformatf("tbl%0d", t));

        for (int it = 0; it < 24; it++) begin
            int n;
            n = $urandom_range(4, 0);
            for (int k = 0; k < n; k++) begin
                bit dup;
                do begin
                    err_pos[k] = $urandom_range(254, 0);
                    dup = 1'b0;
                    for (int m = 0; m < k; m++) if (err_pos[m] == err_pos[k]) dup = 1'b1;
                end while (dup);
                err_val[k] = 8'($urandom_range(255, 1));
            end
            run_vec(make_vec(n), $sformatf("rnd%0d", it));
        end

        // Second syndrome_val while busy must be dropped.
        v = tbl[2];
        @(negedge clk);
        syn_in = v.s;
        syndrome_val = 1'b1;
        @(posedge clk); #1;
        syndrome_val = 1'b0;
        pulses = 0;
        first = -1;
        for (int c = 1; c <= 45; c++) begin
            if (c == 4) begin
                syn_in = tbl[1].s;
                syndrome_val = 1'b1;
            end
            @(posedge clk); #1;
            syndrome_val = 1'b0;
            if (lambda_val) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        check("busy_ignore_pulses", pulses, 1);
        check("busy_ignore_lat", first, Lat);
        check_out(v, "busy_ignore");

        // Accept a new block in the lambda_val cycle.
        run_vec(tbl[1], "b2b_first");
        check("b2b_val_high", {31'd0, lambda_val}, 1);
        v2 = tbl[4];
        syn_in = v2.s;
        syndrome_val = 1'b1;
        @(posedge clk); #1;
        syndrome_val = 1'b0;
        wait_val(lat);
        check("b2b_second_lat", lat, Lat);
        check_out(v2, "b2b_second");

        // Reset mid-operation.
        @(negedge clk);
        syn_in = tbl[2].s;
        syndrome_val = 1'b1;
        @(posedge clk); #1;
        syndrome_val = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (lambda_val) pulses++;
        end
        check("midrst_no_val", pulses, 0);
        run_vec(tbl[2], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
